fractal_pixel_writer: RTL and testbench
=======================================

Name: fractal_pixel_writer

Overview:
Write-side producer for the VGA pixel buffer. It sweeps a raster of pixel coordinates and requests one escape value per pixel from the fractal engine over a req/ack handshake. It then presents each result as a single write beat (coordinate plus data) to the pixel buffer's write port, holding the beat until the buffer accepts it. It signals frame completion back to the top-level controller, which drives the buffer's Draw and draw_frame inputs.

Parameters:
H_RES, 640, pixels per line; x counts 0..H_RES-1
V_RES, 480, lines per frame; y counts 0..V_RES-1
COORD_W, 10, width of the x and y coordinate outputs
ESC_W, 16, width of the engine escape value
PIX_W, 4, width of the stored pixel data

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous abort: return to IDLE and drop the frame in progress
start_frame  in  1  one-cycle request to render a frame; sampled only in IDLE
eng_req  out  1  request an escape value for (eng_x, eng_y)
eng_x  out  COORD_W  current pixel x
eng_y  out  COORD_W  current pixel y
eng_ack  in  1  engine result valid; sampled only while eng_req=1
eng_escape  in  ESC_W  escape value, valid when eng_ack=1
wr_en  out  1  write beat valid
wr_x  out  COORD_W  write x (same value as eng_x)
wr_y  out  COORD_W  write y (same value as eng_y)
wr_data  out  PIX_W  pixel data to store
wr_ready  in  1  buffer accepts the beat this cycle
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset, or clear, in any state takes effect at the next edge:
  - state=IDLE
  - x=0, y=0
  - data register=0
  - all outputs 0
  - clear has priority over every other input; reset has priority over clear.
- FSM states:
  - IDLE: waits for start_frame.
  - REQ: eng_req=1.
  - WRITE: wr_en=1.
  - DONE: frame_done=1 for exactly one cycle.
- IDLE:
  - start_frame=1 -> REQ next cycle, with x=0, y=0.
  - start_frame while busy=1 is ignored; it is not queued.
- REQ:
  - eng_req stays high until eng_ack.
  - eng_ack may arrive in the first REQ cycle.
  - On eng_ack: capture eng_escape into the data register and go to WRITE next cycle.
  - eng_x/eng_y are stable throughout REQ and WRITE.
- WRITE:
  - wr_en, wr_x, wr_y and wr_data are held stable until wr_ready=1.
  - wr_en & wr_ready is the accept. On accept:
    - if x<H_RES-1: x+1, go to REQ.
    - else if y<V_RES-1: x=0, y+1, go to REQ.
    - else (last pixel, x=H_RES-1 and y=V_RES-1): go to DONE.
- DONE: -> IDLE on the next cycle.
- Throughput and latency:
  - Minimum 2 cycles per pixel (eng_ack and wr_ready both high immediately).
  - start_frame to first eng_req: 1 cycle.
  - Last accept to frame_done: 1 cycle.
- Counters never exceed their maximum. Wrap-around happens only through the explicit x=0/y+1 transition; there is no modulo aliasing.
- eng_ack outside REQ and wr_ready outside WRITE are ignored.

Optional Feature:
- Macro: PIXEL_WRITER_CLAMP_EN.
- Defined: wr_data = min(eng_escape, 2^PIX_W-1), i.e. saturation; e.g. escape 37 -> 15.
- Undefined: wr_data = eng_escape[PIX_W-1:0], i.e. truncation; e.g. escape 37 -> 5.
- The conversion is applied when eng_escape is captured into the data register.

Decomposition:
- Shared package (fractal_pkg) holds:
  - the state enum writer_state_t {IDLE, REQ, WRITE, DONE}
  - the default H_RES, V_RES, COORD_W and PIX_W constants, shared with the address translation unit.
- One sub-module, raster_counter: x/y counters with inc and clr inputs, and a last flag asserted at (H_RES-1, V_RES-1).
- The FSM and data register live in the top module.

Test Plan:
1. H_RES=4, V_RES=3; ack and ready tied high; start_frame at t0:
   - eng_req first rises at t1.
   - 12 accepts in (0,0),(1,0)..(3,0),(0,1)..(3,2) order.
   - frame_done at t25.
   - busy high t1..t25.
2. Engine ack delayed 3 cycles, then buffer ready withheld 4 cycles:
   - eng_x/eng_y held throughout.
   - wr_en and wr_data held throughout.
   - Exactly one accept per pixel.
3. eng_escape=37:
   - wr_data=5 without PIXEL_WRITER_CLAMP_EN.
   - wr_data=15 with it.
   - eng_escape=9 gives 9 in both builds.
4. clear asserted mid-WRITE at pixel (2,1):
   - Next cycle IDLE; all outputs 0; no frame_done.
   - A following start_frame restarts at (0,0).
5. start_frame pulsed during REQ and during DONE:
   - Both ignored; exactly one frame_done.
   - A start in the IDLE cycle after DONE starts a new frame.
6. reset asserted together with eng_ack and wr_ready:
   - Next cycle all outputs 0 and state IDLE; no write accepted.

Source files
------------

// File: rtl/fractal_pkg.sv
// Shared types and default raster geometry for the fractal pixel writer
// and the address translation unit.
package fractal_pkg;

  localparam int DEF_H_RES   = 640;
  localparam int DEF_V_RES   = 480;
  localparam int DEF_COORD_W = 10;
  localparam int DEF_ESC_W   = 16;
  localparam int DEF_PIX_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } writer_state_t;

endpackage

// File: rtl/fractal_pixel_writer_raster_counter.sv
// Raster x/y counter: x runs 0..H_RES-1, then wraps to 0 and advances y.
// last_o marks the final pixel (H_RES-1, V_RES-1); inc is ignored there.
module raster_counter
  import fractal_pkg::*;
#(
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               last;

  assign last = (x_q == X_MAX) && (y_q == Y_MAX);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (inc_i && !last) begin
      if (x_q != X_MAX) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = last;

endmodule

// File: rtl/fractal_pixel_writer.sv
// Sweeps the raster, fetches one escape value per pixel from the engine and
// writes it to the pixel buffer. PIXEL_WRITER_CLAMP_EN selects saturation over truncation.
module fractal_pixel_writer
  import fractal_pkg::*;
#(
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int COORD_W = DEF_COORD_W,
  parameter int ESC_W   = DEF_ESC_W,
  parameter int PIX_W   = DEF_PIX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start_frame,
  output logic               eng_req,
  output logic [COORD_W-1:0] eng_x,
  output logic [COORD_W-1:0] eng_y,
  input  logic               eng_ack,
  input  logic [ESC_W-1:0]   eng_escape,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [PIX_W-1:0]   wr_data,
  input  logic               wr_ready,
  output logic               busy,
  output logic               frame_done
);

  // state | meaning: IDLE wait start | REQ eng_req up | WRITE wr_en up | DONE frame_done pulse
  writer_state_t      state_q, state_d;
  logic [PIX_W-1:0]   data_q, data_d;
  logic [COORD_W-1:0] x, y;
  logic               last, accept, cnt_clr;

  function automatic logic [PIX_W-1:0] to_pixel(input logic [ESC_W-1:0] esc);
`ifdef PIXEL_WRITER_CLAMP_EN
    localparam logic [ESC_W-1:0] PIX_MAX = ESC_W'((1 << PIX_W) - 1);
    if (esc > PIX_MAX) return '1;
    return PIX_W'(esc);
`else
    return PIX_W'(esc);
`endif
  endfunction

  assign accept  = (state_q == WRITE) && wr_ready;
  assign cnt_clr = clear || ((state_q == IDLE) && start_frame) || (accept && last);

  raster_counter #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .COORD_W(COORD_W)
  ) u_raster (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (cnt_clr),
    .inc_i  (accept),
    .x_o    (x),
    .y_o    (y),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_frame) state_d = REQ;
      REQ:     if (eng_ack) state_d = WRITE;
      WRITE:   if (wr_ready) state_d = last ? DONE : REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    data_d = data_q;
    if (clear) data_d = '0;
    else if ((state_q == REQ) && eng_ack) data_d = to_pixel(eng_escape);
  end

  always_comb begin
    eng_req    = 1'b0;
    wr_en      = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE:    busy = 1'b0;
      REQ:     eng_req = 1'b1;
      WRITE:   wr_en = 1'b1;
      DONE:    frame_done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign eng_x   = x;
  assign eng_y   = y;
  assign wr_x    = x;
  assign wr_y    = y;
  assign wr_data = data_q;

endmodule

// File: tb/tb_fractal_pixel_writer.sv
// Self-checking bench for fractal_pixel_writer on a 4x3 raster; build with
// PIXEL_WRITER_CLAMP_EN defined to check the saturating conversion.
module tb_fractal_pixel_writer;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int N  = H * V;
  localparam int CW = 10;
  localparam int EW = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset, clear, start_frame;
  logic          eng_req, wr_en, busy, frame_done;
  logic [CW-1:0] eng_x, eng_y, wr_x, wr_y;
  logic [PW-1:0] wr_data;
  logic          eng_ack, wr_ready;
  logic [EW-1:0] eng_escape;

  bit            resp_en;
  logic          m_ack, m_ready, r_ack, r_ready;
  logic [EW-1:0] m_esc, r_esc;

  assign eng_ack    = resp_en ? r_ack   : m_ack;
  assign wr_ready   = resp_en ? r_ready : m_ready;
  assign eng_escape = resp_en ? r_esc   : m_esc;

  always #5 clk = ~clk;

  fractal_pixel_writer #(
    .H_RES(H), .V_RES(V), .COORD_W(CW), .ESC_W(EW), .PIX_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .start_frame(start_frame),
    .eng_req(eng_req), .eng_x(eng_x), .eng_y(eng_y),
    .eng_ack(eng_ack), .eng_escape(eng_escape),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .frame_done(frame_done)
  );

  int checks = 0;
  int failures = 0;

  int exp_x[N];
  int exp_y[N];

  int ack_lo, ack_hi, rdy_lo, rdy_hi, ack_left, rdy_left;
  int pix_idx, accepts, frames, exp_data;
  bit done_pending;

  typedef struct {
    int esc;
    int exp_trunc;
    int exp_clamp;
  } conv_vec_t;

  conv_vec_t cv[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_pix(input int esc);
`ifdef PIXEL_WRITER_CLAMP_EN
    return (esc > 15) ? 15 : esc;
`else
    return esc % 16;
`endif
  endfunction

  function automatic int any_out();
    return (busy || eng_req || wr_en || frame_done || (eng_x != 0) || (eng_y != 0) ||
            (wr_x != 0) || (wr_y != 0) || (wr_data != 0)) ? 1 : 0;
  endfunction

  // Randomised engine/buffer responder with a raster-order scoreboard.
  task automatic respond();
    if (done_pending || frame_done) begin
      chk("frame_done_pulse", int'(frame_done), done_pending ? 1 : 0);
      if (frame_done) frames++;
      done_pending = 0;
    end
    r_ack   = 1'b0;
    r_ready = 1'b0;
    if (eng_req) begin
      chk("req_x", int'(eng_x), exp_x[pix_idx]);
      chk("req_y", int'(eng_y), exp_y[pix_idx]);
      if (ack_left == 0) begin
        r_ack    = 1'b1;
        r_esc    = ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 40))
                                               : EW'($urandom_range(0, 65535));
        exp_data = model_pix(int'(r_esc));
        ack_left = $urandom_range(ack_hi, ack_lo);
      end else begin
        ack_left--;
      end
    end
    if (wr_en) begin
      chk("wr_x", int'(wr_x), exp_x[pix_idx]);
      chk("wr_y", int'(wr_y), exp_y[pix_idx]);
      chk("wr_eng_x", int'(eng_x), exp_x[pix_idx]);
      chk("wr_data", int'(wr_data), exp_data);
      if (rdy_left == 0) begin
        r_ready = 1'b1;
        accepts++;
        if (pix_idx == N - 1) begin
          done_pending = 1;
          pix_idx = 0;
        end else begin
          pix_idx++;
        end
        rdy_left = $urandom_range(rdy_hi, rdy_lo);
      end else begin
        rdy_left--;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (resp_en) respond();
  endtask

  task automatic resp_setup(input int alo, input int ahi, input int rlo, input int rhi);
    ack_lo = alo; ack_hi = ahi; rdy_lo = rlo; rdy_hi = rhi;
    ack_left = $urandom_range(ahi, alo);
    rdy_left = $urandom_range(rhi, rlo);
    pix_idx = 0;
    done_pending = 0;
    r_ack = 1'b0;
    r_ready = 1'b0;
    r_esc = '0;
    resp_en = 1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      cyc();
      n++;
    end
    chk("frame_complete", frames, target);
    cyc();
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!eng_req && n < 20) begin
      cyc();
      n++;
    end
    chk(name, int'(eng_req), 1);
  endtask

  task automatic start_pulse();
    start_frame = 1'b1;
    cyc();
    start_frame = 1'b0;
  endtask

  task automatic fast_pixel();
    wait_req("fast_req");
    m_ack = 1'b1;
    cyc();
    m_ack = 1'b0;
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, a0, n, exp;

    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++) begin
        exp_x[yy * H + xx] = xx;
        exp_y[yy * H + xx] = yy;
      end

    cv[0] = '{37, 5, 15};
    cv[1] = '{9, 9, 9};
    cv[2] = '{0, 0, 0};
    cv[3] = '{15, 15, 15};
    cv[4] = '{16, 0, 15};
    cv[5] = '{65535, 15, 15};
    cv[6] = '{50, 2, 15};

    resp_en = 0;
    reset = 1'b1; clear = 1'b0; start_frame = 1'b0;
    m_ack = 1'b0; m_ready = 1'b0; m_esc = '0;
    r_ack = 1'b0; r_ready = 1'b0; r_esc = '0;
    accepts = 0; frames = 0; exp_data = 0;
    repeat (3) cyc();
    chk("reset_outs", any_out(), 0);
    reset = 1'b0;
    cyc();
    chk("post_reset_outs", any_out(), 0);

    // Full-rate frame with exact cycle timing.
    resp_setup(0, 0, 0, 0);
    f0 = frames; a0 = accepts;
    start_frame = 1'b1;
    for (int t = 1; t <= 27; t++) begin
      cyc();
      start_frame = 1'b0;
      if (t == 1) chk("t1_first_req", int'(eng_req), 1);
      chk("t1_busy", int'(busy), (t <= 25) ? 1 : 0);
      chk("t1_frame_done", int'(frame_done), (t == 25) ? 1 : 0);
    end
    chk("t1_accepts", accepts - a0, N);
    chk("t1_frames", frames - f0, 1);

    // Ack delayed 3 cycles, ready withheld 4 cycles.
    resp_setup(3, 3, 4, 4);
    f0 = frames; a0 = accepts;
    start_pulse();
    wait_frames(f0 + 1, 400);
    chk("t2_accepts", accepts - a0, N);

    // Random handshake delays over two frames.
    resp_setup(0, 3, 0, 3);
    f0 = frames; a0 = accepts;
    for (int k = 0; k < 2; k++) begin
      start_pulse();
      wait_frames(f0 + k + 1, 400);
    end
    chk("rand_accepts", accepts - a0, 2 * N);

    // start_frame during REQ and during DONE is ignored.
    resp_setup(1, 2, 0, 1);
    f0 = frames;
    start_pulse();
    wait_req("t5_req");
    start_frame = 1'b1;
    cyc();
    start_frame = 1'b0;
    n = 0;
    while (!frame_done && n < 200) begin
      cyc();
      n++;
    end
    chk("t5_done_seen", int'(frame_done), 1);
    start_frame = 1'b1;
    cyc();
    start_frame = 1'b0;
    chk("t5_idle_after_done", int'(busy), 0);
    chk("t5_one_done", frames - f0, 1);
    start_pulse();
    chk("t5_restart_req", int'(eng_req), 1);
    chk("t5_restart_x", int'(eng_x), 0);
    chk("t5_restart_y", int'(eng_y), 0);
    wait_frames(f0 + 2, 400);
    resp_en = 0;

    // Escape-to-pixel conversion table, with one cycle of ready hold.
    cyc();
    start_pulse();
    for (int i = 0; i < 7; i++) begin
`ifdef PIXEL_WRITER_CLAMP_EN
      exp = cv[i].exp_clamp;
`else
      exp = cv[i].exp_trunc;
`endif
      wait_req("conv_req");
      m_esc = EW'(cv[i].esc);
      m_ack = 1'b1;
      cyc();
      m_ack = 1'b0;
      m_esc = '0;
      chk("conv_wr_en", int'(wr_en), 1);
      chk("conv_wr_x", int'(wr_x), i % H);
      chk("conv_data", int'(wr_data), exp);
      cyc();
      chk("conv_data_hold", int'(wr_data), exp);
      m_ready = 1'b1;
      cyc();
      m_ready = 1'b0;
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("conv_clear_outs", any_out(), 0);

    // clear in WRITE at pixel (2,1), with wr_ready high.
    start_pulse();
    for (int p = 0; p < 6; p++) fast_pixel();
    wait_req("t4_req");
    m_esc = EW'(37);
    m_ack = 1'b1;
    cyc();
    m_ack = 1'b0;
    chk("t4_wr_en", int'(wr_en), 1);
    chk("t4_wr_x", int'(wr_x), 2);
    chk("t4_wr_y", int'(wr_y), 1);
    clear = 1'b1;
    m_ready = 1'b1;
    cyc();
    clear = 1'b0;
    m_ready = 1'b0;
    chk("t4_clear_outs", any_out(), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t4_stay_idle", any_out(), 0);
    end
    start_pulse();
    chk("t4_restart_req", int'(eng_req), 1);
    chk("t4_restart_x", int'(eng_x), 0);
    chk("t4_restart_y", int'(eng_y), 0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;

    // reset together with eng_ack (in REQ) and wr_ready (in WRITE).
    start_pulse();
    wait_req("t6_req");
    reset = 1'b1;
    m_ack = 1'b1;
    m_ready = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_reset_req_outs", any_out(), 0);
    cyc();
    chk("t6_ack_ignored", any_out(), 0);
    m_ack = 1'b0;
    m_ready = 1'b0;
    start_pulse();
    fast_pixel();
    wait_req("t6_req2");
    m_esc = EW'(9);
    m_ack = 1'b1;
    cyc();
    m_ack = 1'b0;
    chk("t6_wr_x", int'(wr_x), 1);
    reset = 1'b1;
    m_ready = 1'b1;
    cyc();
    reset = 1'b0;
    m_ready = 1'b0;
    chk("t6_reset_wr_outs", any_out(), 0);
    start_pulse();
    chk("t6_restart_x", int'(eng_x), 0);
    chk("t6_restart_y", int'(eng_y), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
